// File: rtl/tri_raster_pkg.sv
// Shared types and constants for the triangle rasterizer and its area unit.
`timescale 1ns/1ps
package tri_raster_pkg;

  localparam int COORD_W = 9;
  localparam int AREA_W  = 2 * COORD_W + 2;
  // Three sub-areas can sum to just under 3x the largest twice-area.
  localparam int ACC_W   = AREA_W + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    AR0   = 3'd2,
    AR1   = 3'd3,
    AR2   = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tri_area2.sv
// Combinational twice-area |Px(Qy-Ry) + Qx(Ry-Py) + Rx(Py-Qy)| of three points.
`timescale 1ns/1ps
module tri_area2
  import tri_raster_pkg::*;
(
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  input  logic [COORD_W-1:0] q_x,
  input  logic [COORD_W-1:0] q_y,
  input  logic [COORD_W-1:0] r_x,
  input  logic [COORD_W-1:0] r_y,
  output logic [AREA_W-1:0]  area
);

  localparam int SUM_W = 2 * COORD_W + 3;

  logic signed [COORD_W:0] d_qr_s;
  logic signed [COORD_W:0] d_rp_s;
  logic signed [COORD_W:0] d_pq_s;
  logic signed [SUM_W-1:0] sum_s;

  assign d_qr_s = $signed({1'b0, q_y}) - $signed({1'b0, r_y});
  assign d_rp_s = $signed({1'b0, r_y}) - $signed({1'b0, p_y});
  assign d_pq_s = $signed({1'b0, p_y}) - $signed({1'b0, q_y});

  // Every operand is widened to the full signed sum width so nothing truncates.
  assign sum_s = SUM_W'($signed({1'b0, p_x})) * SUM_W'(d_qr_s)
               + SUM_W'($signed({1'b0, q_x})) * SUM_W'(d_rp_s)
               + SUM_W'($signed({1'b0, r_x})) * SUM_W'(d_pq_s);

  assign area = sum_s[SUM_W-1] ? AREA_W'(-sum_s) : AREA_W'(sum_s);

endmodule

// File: rtl/triangle_raster.sv
// Bounding-box scan rasterizer using the sub-triangle area-sum inside test.
// Optional build macro RASTER_EMIT_ALL_EN: emit every box pixel with its test result.
`timescale 1ns/1ps
module triangle_raster
  import tri_raster_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               pix_inside,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               done
);

  state_t state_r, state_s;

  logic [COORD_W-1:0] ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
  logic [COORD_W-1:0] px_r, py_r;
  logic [COORD_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic [AREA_W-1:0]  ttot_r;
  logic [ACC_W-1:0]   acc_r;
  logic               busy_r, done_r, pix_valid_r, pix_inside_r;

  logic [AREA_W-1:0]  ttot_s, sub_s;
  logic [COORD_W-1:0] q_x_s, q_y_s, r_x_s, r_y_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic               inside_s, emit_s, last_s, advance_s;

  tri_area2 u_ttot (
    .p_x (ax_r), .p_y (ay_r),
    .q_x (bx_r), .q_y (by_r),
    .r_x (cx_r), .r_y (cy_r),
    .area(ttot_s)
  );

  // Route the edge pair for the current sub-area state to the shared unit.
  always_comb begin
    q_x_s = ax_r;
    q_y_s = ay_r;
    r_x_s = bx_r;
    r_y_s = by_r;
    case (state_r)
      AR1: begin
        q_x_s = bx_r; q_y_s = by_r; r_x_s = cx_r; r_y_s = cy_r;
      end
      AR2: begin
        q_x_s = cx_r; q_y_s = cy_r; r_x_s = ax_r; r_y_s = ay_r;
      end
      default: begin
        q_x_s = ax_r; q_y_s = ay_r; r_x_s = bx_r; r_y_s = by_r;
      end
    endcase
  end

  tri_area2 u_sub (
    .p_x (px_r),  .p_y (py_r),
    .q_x (q_x_s), .q_y (q_y_s),
    .r_x (r_x_s), .r_y (r_y_s),
    .area(sub_s)
  );

  assign acc_sum_s = acc_r + ACC_W'(sub_s);
  assign inside_s  = (acc_sum_s == ACC_W'(ttot_r));
  assign last_s    = (px_r == xmax_r) && (py_r == ymax_r);

`ifdef RASTER_EMIT_ALL_EN
  assign emit_s = 1'b1;
`else
  assign emit_s = inside_s;
`endif

  // Next-state decode and the pixel-advance strobe.
  always_comb begin
    state_s   = state_r;
    advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_s = SETUP;
        else       state_s = IDLE;
      end
      SETUP: begin
        if (ttot_s == '0) state_s = DONE;
        else              state_s = AR0;
      end
      AR0: state_s = AR1;
      AR1: state_s = AR2;
      AR2: begin
        if (emit_s) begin
          state_s = EMIT;
        end else begin
          advance_s = 1'b1;
          state_s   = last_s ? DONE : AR0;
        end
      end
      EMIT: begin
        if (pix_ready) begin
          advance_s = 1'b1;
          state_s   = last_s ? DONE : AR0;
        end else begin
          state_s = EMIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Vertex latch, triangle setup, raster position and area accumulator.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ax_r <= '0; ay_r <= '0; bx_r <= '0; by_r <= '0; cx_r <= '0; cy_r <= '0;
      xmin_r <= '0; xmax_r <= '0; ymin_r <= '0; ymax_r <= '0;
      px_r <= '0; py_r <= '0;
      ttot_r <= '0;
      acc_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            ax_r <= ax; ay_r <= ay; bx_r <= bx; by_r <= by; cx_r <= cx; cy_r <= cy;
          end
        end
        SETUP: begin
          ttot_r <= ttot_s;
          xmin_r <= min3(ax_r, bx_r, cx_r);
          xmax_r <= max3(ax_r, bx_r, cx_r);
          ymin_r <= min3(ay_r, by_r, cy_r);
          ymax_r <= max3(ay_r, by_r, cy_r);
          px_r   <= min3(ax_r, bx_r, cx_r);
          py_r   <= min3(ay_r, by_r, cy_r);
          acc_r  <= '0;
        end
        AR0, AR1: acc_r <= acc_sum_s;
        AR2: begin
          if (advance_s) acc_r <= '0;
          else           acc_r <= acc_sum_s;
        end
        EMIT: begin
          if (advance_s) acc_r <= '0;
        end
        default: ;
      endcase
      // The final pixel keeps its coordinate; the scan ends there.
      if (advance_s && !last_s) begin
        if (px_r == xmax_r) begin
          px_r <= xmin_r;
          py_r <= py_r + COORD_W'(1);
        end else begin
          px_r <= px_r + COORD_W'(1);
        end
      end
    end
  end

  // Registered handshake and status outputs, decoded from the next state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pix_valid_r  <= 1'b0;
      pix_inside_r <= 1'b0;
    end else begin
      busy_r      <= (state_s == SETUP) || (state_s == AR0) || (state_s == AR1) ||
                     (state_s == AR2)   || (state_s == EMIT);
      done_r      <= (state_s == DONE);
      pix_valid_r <= (state_s == EMIT);
      if (state_r == AR2 && state_s == EMIT) pix_inside_r <= inside_s;
      else if (state_s != EMIT)              pix_inside_r <= 1'b0;
    end
  end

  assign px         = px_r;
  assign py         = py_r;
  assign pix_inside = pix_inside_r;
  assign pix_valid  = pix_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_triangle_raster.sv
// Self-checking bench for triangle_raster against an integer coverage model.
`timescale 1ns/1ps
module tb_triangle_raster;

`ifdef RASTER_EMIT_ALL_EN
  localparam bit EMIT_ALL = 1'b1;
`else
  localparam bit EMIT_ALL = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start    = 1'b0;
  logic [8:0] ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
  logic [8:0] px, py;
  logic       pix_inside, pix_valid, busy, done;
  logic       pix_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  // expected stream from the model
  int exp_x[$], exp_y[$], exp_i[$];
  int exp_done, exp_box, exp_in;
  // observed stream
  int obs_x[$], obs_y[$], obs_i[$];
  int obs_done, obs_pulses, obs_busy, obs_valid, obs_stall, obs_unstable, obs_timeout;
  int snap_ok, snap_inside;
  int ab_sum;

  triangle_raster dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .start     (start),
    .ax        (ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .px        (px),
    .py        (py),
    .pix_inside(pix_inside),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int t2(int pxx, int pyy, int qx, int qy, int rx, int ry);
    int s;
    s = pxx * (qy - ry) + qx * (ry - pyy) + rx * (pyy - qy);
    return (s < 0) ? -s : s;
  endfunction

  // Reference: walk the bounding box in raster order, classify every pixel.
  task automatic model(input int a_x, a_y, b_x, b_y, c_x, c_y);
    int tot, x0, x1, y0, y1, n_emit, ins;
    exp_x.delete(); exp_y.delete(); exp_i.delete();
    exp_box = 0; exp_in = 0;
    tot = t2(a_x, a_y, b_x, b_y, c_x, c_y);
    if (tot == 0) begin
      exp_done = 2;
      return;
    end
    x0 = a_x; if (b_x < x0) x0 = b_x; if (c_x < x0) x0 = c_x;
    x1 = a_x; if (b_x > x1) x1 = b_x; if (c_x > x1) x1 = c_x;
    y0 = a_y; if (b_y < y0) y0 = b_y; if (c_y < y0) y0 = c_y;
    y1 = a_y; if (b_y > y1) y1 = b_y; if (c_y > y1) y1 = c_y;
    n_emit = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        ins = (t2(x, y, a_x, a_y, b_x, b_y) + t2(x, y, b_x, b_y, c_x, c_y) +
               t2(x, y, c_x, c_y, a_x, a_y)) == tot;
        exp_box++;
        exp_in += ins;
        if (EMIT_ALL || ins) begin
          exp_x.push_back(x); exp_y.push_back(y); exp_i.push_back(ins);
          n_emit++;
        end
      end
    end
    exp_done = 2 + 3 * exp_box + n_emit;
  endtask

  // Drive one scan and record what the DUT produced (no checking here).
  task automatic run_scan(input int a_x, a_y, b_x, b_y, c_x, c_y,
                          input int stall_x, stall_y, stall_n,
                          input int restart_at, abort_at, input bit rand_ready);
    int c, stall_left;
    obs_x.delete(); obs_y.delete(); obs_i.delete();
    obs_done = -1; obs_pulses = 0; obs_busy = 0; obs_valid = 0; obs_stall = 0;
    obs_unstable = 0; obs_timeout = 0; snap_ok = 0; snap_inside = -1; ab_sum = -1;
    stall_left = stall_n;
    @(negedge CLOCK_50);
    ax = 9'(a_x); ay = 9'(a_y); bx = 9'(b_x); by = 9'(b_y); cx = 9'(c_x); cy = 9'(c_y);
    start = 1'b1; pix_ready = 1'b1;
    @(posedge CLOCK_50);
    c = 0;
    while (1) begin
      @(negedge CLOCK_50);
      c++;
      start = (c == restart_at);
      if (c == restart_at) begin
        ax = 9'd5; ay = 9'd5; bx = 9'd9; by = 9'd5; cx = 9'd5; cy = 9'd9;
      end
      if (c == abort_at) begin
        reset_n = 1'b0;
        #1;
        ab_sum = int'(busy) + int'(done) + int'(pix_valid) + int'(pix_inside) + int'(px) + int'(py);
        break;
      end
      if (busy) obs_busy++;
      if (done) begin
        obs_pulses++;
        if (obs_done < 0) obs_done = c;
      end
      if (pix_valid && px == stall_x && py == stall_y && stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (pix_valid) begin
        obs_valid++;
        if (px == stall_x && py == stall_y) begin
          if (!snap_ok) begin
            snap_ok = 1; snap_inside = pix_inside;
          end else if (pix_inside !== snap_inside[0]) begin
            obs_unstable++;
          end
        end
        if (!pix_ready) obs_stall++;
        else begin
          obs_x.push_back(px); obs_y.push_back(py); obs_i.push_back(pix_inside);
        end
      end else if (snap_ok && stall_left > 0) begin
        obs_unstable++;
      end
      if (obs_done >= 0 && c >= obs_done + 2) break;
      if (c > 20000) begin
        obs_timeout = 1;
        break;
      end
    end
    start = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (pix_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid got=%b want=0", pix_valid); end
    n_cmp++; if (pix_inside !== 1'b0) begin n_err++; $display("FAIL reset_inside got=%b want=0", pix_inside); end
    n_cmp++; if (px !== 9'd0)         begin n_err++; $display("FAIL reset_px got=%0d want=0", px); end
    n_cmp++; if (py !== 9'd0)         begin n_err++; $display("FAIL reset_py got=%0d want=0", py); end
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_basic_triangle;
    model(0, 0, 4, 0, 0, 4);
    run_scan(0, 0, 4, 0, 0, 4, -1, -1, 0, -1, -1, 1'b0);
    n_cmp++; if (obs_timeout != 0) begin n_err++; $display("FAIL basic_timeout got=%0d want=0", obs_timeout); end
    n_cmp++; if (obs_x.size() != (EMIT_ALL ? 25 : 15))
      begin n_err++; $display("FAIL basic_count got=%0d want=%0d", obs_x.size(), EMIT_ALL ? 25 : 15); end
    n_cmp++; if (exp_in != 15) begin n_err++; $display("FAIL basic_model_inside got=%0d want=15", exp_in); end
    n_cmp++; if (obs_done != (EMIT_ALL ? 102 : 92))
      begin n_err++; $display("FAIL basic_done_cycle got=%0d want=%0d", obs_done, EMIT_ALL ? 102 : 92); end
    for (int k = 0; k < exp_x.size() && k < obs_x.size(); k++) begin
      n_cmp++;
      if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k] || obs_i[k] != exp_i[k] ||
          (obs_i[k] == 1) != (exp_x[k] + exp_y[k] <= 4)) begin
        n_err++;
        $display("FAIL basic_pixel%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                 k, obs_x[k], obs_y[k], obs_i[k], exp_x[k], exp_y[k], exp_i[k]);
      end
    end
    n_cmp++; if (obs_pulses != 1) begin n_err++; $display("FAIL basic_done_pulses got=%0d want=1", obs_pulses); end
  endtask

  task automatic test_degenerate;
    model(1, 1, 2, 2, 3, 3);
    run_scan(1, 1, 2, 2, 3, 3, -1, -1, 0, -1, -1, 1'b0);
    n_cmp++; if (obs_valid != 0) begin n_err++; $display("FAIL degen_valid got=%0d want=0", obs_valid); end
    n_cmp++; if (obs_done != exp_done || obs_done != 2)
      begin n_err++; $display("FAIL degen_done_cycle got=%0d want=2", obs_done); end
    n_cmp++; if (obs_busy != 1) begin n_err++; $display("FAIL degen_busy_cycles got=%0d want=1", obs_busy); end
  endtask

  task automatic test_stall;
    model(0, 0, 4, 0, 0, 4);
    run_scan(0, 0, 4, 0, 0, 4, 2, 1, 5, -1, -1, 1'b0);
    n_cmp++; if (obs_done != exp_done + 5)
      begin n_err++; $display("FAIL stall_done_cycle got=%0d want=%0d", obs_done, exp_done + 5); end
    n_cmp++; if (obs_stall != 5) begin n_err++; $display("FAIL stall_cycles got=%0d want=5", obs_stall); end
    n_cmp++; if (obs_unstable != 0) begin n_err++; $display("FAIL stall_stable got=%0d want=0", obs_unstable); end
    n_cmp++; if (snap_inside != 1) begin n_err++; $display("FAIL stall_inside got=%0d want=1", snap_inside); end
    n_cmp++; if (obs_x.size() != exp_x.size())
      begin n_err++; $display("FAIL stall_count got=%0d want=%0d", obs_x.size(), exp_x.size()); end
  endtask

  task automatic test_restart_ignored;
    model(0, 0, 4, 0, 0, 4);
    run_scan(0, 0, 4, 0, 0, 4, -1, -1, 0, 10, -1, 1'b0);
    n_cmp++; if (obs_done != exp_done)
      begin n_err++; $display("FAIL restart_done_cycle got=%0d want=%0d", obs_done, exp_done); end
    n_cmp++; if (obs_x.size() != exp_x.size())
      begin n_err++; $display("FAIL restart_count got=%0d want=%0d", obs_x.size(), exp_x.size()); end
    for (int k = 0; k < exp_x.size() && k < obs_x.size(); k++) begin
      n_cmp++;
      if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k] || obs_i[k] != exp_i[k]) begin
        n_err++;
        $display("FAIL restart_pixel%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                 k, obs_x[k], obs_y[k], obs_i[k], exp_x[k], exp_y[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    run_scan(0, 0, 4, 0, 0, 4, -1, -1, 0, -1, 40, 1'b0);
    n_cmp++; if (ab_sum != 0) begin n_err++; $display("FAIL midreset_outputs got=%0d want=0", ab_sum); end
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    model(3, 2, 9, 4, 5, 8);
    run_scan(3, 2, 9, 4, 5, 8, -1, -1, 0, -1, -1, 1'b0);
    n_cmp++; if (obs_x.size() == 0 || obs_done != exp_done || obs_x.size() != exp_x.size())
      begin n_err++; $display("FAIL midreset_rescan got=%0d/%0d want=%0d/%0d",
                              obs_done, obs_x.size(), exp_done, exp_x.size()); end
    for (int k = 0; k < exp_x.size() && k < obs_x.size(); k++) begin
      n_cmp++;
      if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k] || obs_i[k] != exp_i[k]) begin
        n_err++;
        $display("FAIL midreset_pixel%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                 k, obs_x[k], obs_y[k], obs_i[k], exp_x[k], exp_y[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_random;
    int v[6], base_x, base_y;
    for (int t = 0; t < 10; t++) begin
      base_x = $urandom_range(0, 498);
      base_y = $urandom_range(0, 498);
      for (int j = 0; j < 6; j++) v[j] = ((j % 2) ? base_y : base_x) + $urandom_range(0, 12);
      model(v[0], v[1], v[2], v[3], v[4], v[5]);
      run_scan(v[0], v[1], v[2], v[3], v[4], v[5], -1, -1, 0, -1, -1, 1'b1);
      n_cmp++; if (obs_done != exp_done + obs_stall)
        begin n_err++; $display("FAIL rand%0d_done_cycle got=%0d want=%0d", t, obs_done, exp_done + obs_stall); end
      n_cmp++; if (obs_x.size() != exp_x.size())
        begin n_err++; $display("FAIL rand%0d_count got=%0d want=%0d", t, obs_x.size(), exp_x.size()); end
      for (int k = 0; k < exp_x.size() && k < obs_x.size(); k++) begin
        n_cmp++;
        if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k] || obs_i[k] != exp_i[k]) begin
          n_err++;
          $display("FAIL rand%0d_pixel%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                   t, k, obs_x[k], obs_y[k], obs_i[k], exp_x[k], exp_y[k], exp_i[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_triangle();
    test_degenerate();
    test_stall();
    test_restart_ignored();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
